// File: rtl/fir_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_fsm
// Description : Control path for a 3-tap transposed-form FIR datapath.
//               Takes samples from a source over valid/ready, sequences the
//               datapath load strobes (ld_x, then ld_delay1/ld_delay2/ld_y),
//               and presents the result over valid/ready with backpressure.
//               Tracks filter warm-up (primed) and counts accepted samples.
// Ports       :
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous abort to IDLE, clears counters
//   in_valid   in   source offers a sample on datapath x
//   in_ready   out  controller accepts a sample this cycle (registered)
//   ld_x       out  datapath: load input register
//   ld_delay1  out  datapath: load delay1
//   ld_delay2  out  datapath: load delay2
//   ld_y       out  datapath: load output register
//   out_valid  out  datapath y holds a new result
//   out_ready  in   sink consumes y
//   primed     out  TAPS-1 or more samples loaded since reset/flush
//   sample_cnt out  samples accepted since reset/flush (wrapping)
//   busy       out  FSM not in IDLE
// Config      : FIR_CTRL_WARMUP_SUPPRESS_EN - when defined, unprimed
//               (warm-up) results are discarded: SHIFT returns to IDLE
//               without visiting OUT.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl_fsm #(
    parameter int TAPS      = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ld_x,
    output logic                 ld_delay1,
    output logic                 ld_delay2,
    output logic                 ld_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 primed,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    // Count value at which the filter window is full.
    localparam logic [CNT_WIDTH-1:0] PRIME_CNT = CNT_WIDTH'(TAPS - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 handshake;
    logic                 shift_fire;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // A flush in the same cycle cancels the handshake and any shift strobes:
    // nothing is loaded and nothing is counted.
    assign handshake  = (state == ST_IDLE) && in_valid && in_ready && !flush;
    assign shift_fire = (state == ST_SHIFT) && !flush;
    assign cnt_inc    = sample_cnt + CNT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
`ifdef FIR_CTRL_WARMUP_SUPPRESS_EN
                    // primed already reflects the sample loaded last cycle.
                    state_nxt = primed ? ST_OUT : ST_IDLE;
`else
                    state_nxt = ST_OUT;
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            sample_cnt <= '0;
            primed     <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Registered ready: high exactly while the FSM sits in IDLE,
            // except for the first cycle after reset release.
            in_ready <= (state_nxt == ST_IDLE);
            if (flush) begin
                sample_cnt <= '0;
                primed     <= 1'b0;
            end else if (handshake) begin
                sample_cnt <= cnt_inc;
                // Sticky: a later counter wrap does not clear it.
                if (cnt_inc == PRIME_CNT) begin
                    primed <= 1'b1;
                end
            end
        end
    end

    assign ld_x      = handshake;
    assign ld_delay1 = shift_fire;
    assign ld_delay2 = shift_fire;
    assign ld_y      = shift_fire;
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_ctrl_fsm
// Description : Self-checking bench for fir_ctrl_fsm. A small transaction-
//               level model (accepted-sample timestamps, counters) predicts
//               every output each cycle; a behavioural FIR datapath driven by
//               the DUT strobes checks end-to-end results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_ctrl_fsm;

    localparam int TAPS = 3;
    localparam int CW   = 4;
`ifdef FIR_CTRL_WARMUP_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, ld_x, ld_delay1, ld_delay2, ld_y, out_valid, primed, busy;
    logic [CW-1:0] sample_cnt;
    logic signed [15:0] x = '0;

    always #5 clk = ~clk;

    fir_ctrl_fsm #(.TAPS(TAPS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ld_x(ld_x), .ld_delay1(ld_delay1), .ld_delay2(ld_delay2), .ld_y(ld_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .primed(primed), .sample_cnt(sample_cnt), .busy(busy)
    );

    // Behavioural transposed FIR, Q8 taps h0=64, h1=128, h2=64.
    logic signed [31:0] dp_x, dp_d1, dp_d2, dp_y;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_x <= 0; dp_d1 <= 0; dp_d2 <= 0; dp_y <= 0;
        end else begin
            if (ld_x)      dp_x  <= 32'(x);
            if (ld_delay1) dp_d1 <= dp_x * 64;
            if (ld_delay2) dp_d2 <= dp_d1 + dp_x * 128;
            if (ld_y)      dp_y  <= dp_d2 + dp_x * 64;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whether a sample is in flight and when it was taken.
    bit            m_out;
    bit            m_primed;
    int            m_hs;
    int            m_t;
    logic [CW-1:0] m_cnt;

    logic [CW+7:0]      exp_v, obs_v;
    logic signed [31:0] obs_y;

    task automatic tick(input logic iv, input logic ordy, input logic fl, input logic [15:0] xv);
        bit e_ir, e_lx, e_sh, e_ov;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; flush = fl; x = xv;
        #1;
        e_ir  = !m_out;
        e_lx  = e_ir && iv && !fl;
        e_sh  = m_out && (m_t == m_hs + 1) && !fl;
        e_ov  = m_out && (m_t >= m_hs + 2);
        exp_v = {e_ir, e_lx, e_sh, e_sh, e_sh, e_ov, m_out, m_primed, m_cnt};
        obs_v = {in_ready, ld_x, ld_delay1, ld_delay2, ld_y, out_valid, busy, primed, sample_cnt};
        obs_y = dp_y >>> 8;
        @(posedge clk);
        if (fl) begin
            m_out = 1'b0; m_cnt = '0; m_primed = 1'b0;
        end else if (e_lx) begin
            m_out = 1'b1; m_hs = m_t; m_cnt = m_cnt + 1'b1;
            if (int'(m_cnt) == TAPS - 1) m_primed = 1'b1;
        end else if (e_ov && ordy) begin
            m_out = 1'b0;
        end else if (SUPP && m_out && (m_t == m_hs + 1) && !m_primed) begin
            m_out = 1'b0;
        end
        m_t++;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        m_out = 1'b0; m_cnt = '0; m_primed = 1'b0; m_hs = -10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({in_ready, ld_x, ld_delay1, ld_delay2, ld_y, out_valid, busy, primed, sample_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_state got=%b want=0", {in_ready, ld_x, out_valid, busy, primed, sample_cnt});
        end
        do_reset();
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_after_release got=%b want=0", in_ready);
        end
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_cmp++;
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_idle got=%b want=%b", obs_v, exp_v); end
        tick(1'b1, 1'b0, 1'b0, 16'd5);
        n_cmp++;
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_hs got=%b want=%b", obs_v, exp_v); end
        // Now in SHIFT: strobes up, then async reset mid-cycle.
        @(negedge clk); #1;
        n_cmp++;
        if (ld_delay1 !== 1'b1) begin n_bad++; $display("FAIL shift_strobe got=%b want=1", ld_delay1); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, ld_x, ld_delay1, ld_delay2, ld_y, out_valid, busy, primed, sample_cnt} !== '0) begin
            n_bad++; $display("FAIL async_reset got=%b want=0", {in_ready, ld_x, ld_delay1, out_valid, busy, primed, sample_cnt});
        end
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            tick(i == 0, 1'b1, 1'b0, 16'd9);
            n_cmp++;
            if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_resume i=%0d got=%b want=%b", i, obs_v, exp_v); end
        end
    endtask

    task automatic test_stream();
        int nov;
        int nhs;
        int want_y [4];
        if (SUPP) want_y = '{128, 64, 0, 0};
        else      want_y = '{64, 128, 64, 0};
        nov = 0; nhs = 0;
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 13; i++) begin
            tick(1'b1, 1'b1, 1'b0, (nhs == 0) ? 16'd256 : 16'd0);
            if (exp_v[CW+6]) nhs++;
            n_cmp++;
            if (obs_v !== exp_v) begin n_bad++; $display("FAIL stream i=%0d got=%b want=%b", i, obs_v, exp_v); end
            if (obs_v[CW+2] === 1'b1) begin
                n_cmp++;
                if (nov < 4 && obs_y !== want_y[nov]) begin
                    n_bad++; $display("FAIL stream_y n=%0d got=%0d want=%0d", nov, obs_y, want_y[nov]);
                end
                nov++;
            end
        end
        n_cmp++;
        if (nov !== (SUPP ? 3 : 4)) begin
            n_bad++; $display("FAIL stream_count got=%0d want=%0d", nov, SUPP ? 3 : 4);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 16'd0);
        end
        tick(1'b1, 1'b0, 1'b1, 16'd3);
        n_cmp++;
        if (obs_v !== exp_v || obs_v[CW+6] !== 1'b0) begin
            n_bad++; $display("FAIL flush_cycle got=%b want=%b", obs_v, exp_v);
        end
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_cmp++;
        if (obs_v !== exp_v || obs_v[CW:0] !== '0) begin
            n_bad++; $display("FAIL flush_clear got=%b want=%b", obs_v, exp_v);
        end
        tick(1'b1, 1'b1, 1'b0, 16'd3);
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        n_cmp++;
        if (obs_v !== exp_v || obs_v[CW-1:0] !== 4'd1) begin
            n_bad++; $display("FAIL flush_next_cnt got=%b want=%b", obs_v, exp_v);
        end
        tick(1'b0, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (!(m_cnt == 4'hF && !m_out) && guard < 100) begin
            tick(1'b1, 1'b1, 1'b0, 16'd1);
            guard++;
            n_cmp++;
            if (obs_v !== exp_v) begin n_bad++; $display("FAIL wrap_run g=%0d got=%b want=%b", guard, obs_v, exp_v); end
        end
        n_cmp++;
        if (guard >= 100) begin n_bad++; $display("FAIL wrap_timeout got=%0d want<100", guard); end
        tick(1'b1, 1'b1, 1'b0, 16'd1);
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        n_cmp++;
        if (obs_v[CW-1:0] !== 4'd0 || obs_v[CW] !== 1'b1) begin
            n_bad++; $display("FAIL wrap_value got cnt=%0d primed=%b want cnt=0 primed=1", obs_v[CW-1:0], obs_v[CW]);
        end
        repeat (3) tick(1'b0, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic test_backpressure();
        int nov;
        logic signed [31:0] y0;
        nov = 0;
        tick(1'b1, 1'b0, 1'b0, 16'd100);
        tick(1'b1, 1'b0, 1'b0, 16'd100);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 16'd7);
            if (i == 0) y0 = obs_y;
            if (obs_v[CW+2] === 1'b1) nov++;
            n_cmp++;
            if (obs_v !== exp_v || obs_y !== y0) begin
                n_bad++; $display("FAIL stall i=%0d got=%b want=%b y=%0d", i, obs_v, exp_v, obs_y);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        if (obs_v[CW+2] === 1'b1) nov++;
        tick(1'b0, 1'b1, 1'b0, 16'd0);
        if (obs_v[CW+2] === 1'b1) nov++;
        n_cmp++;
        if (obs_v !== exp_v || nov !== 11) begin
            n_bad++; $display("FAIL stall_release got=%b want=%b ov_cycles=%0d want=11", obs_v, exp_v, nov);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom % 2), 1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0),
                 16'($urandom % 512));
            n_cmp++;
            if (obs_v !== exp_v) begin n_bad++; $display("FAIL random i=%0d got=%b want=%b", i, obs_v, exp_v); end
        end
    endtask

    initial begin
        m_out = 1'b0; m_cnt = '0; m_primed = 1'b0; m_hs = -10; m_t = 0;
        test_reset();
        test_stream();
        test_flush();
        test_wrap();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
